// File: rtl/class_result_filter_pkg.sv
// Shared constants and FSM encoding for the class result filter that drives the LED code.
// The LED driver imports the same IDLE code so "all LEDs on" means the same thing on both sides.
`timescale 1ns/1ps
package class_result_filter_pkg;

  localparam int              CODE_W          = 3;
  localparam logic [CODE_W-1:0] CRF_IDLE_CODE = 3'b111;
  localparam int              CRF_NUM_CLASSES = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISPLAY = 2'd3
  } state_e;

endpackage

// File: rtl/class_result_filter_cycle_timer.sv
// Saturating up-counter with synchronous clear, count enable and a terminal-count flag at MAX-1.
`timescale 1ns/1ps
module class_result_filter_cycle_timer #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && count != W'(MAX))
      count <= count + W'(1);
  end

  assign tc = (count == W'(MAX - 1));

endmodule

// File: rtl/class_result_filter.sv
// Debounces classifier results, holds each committed class for a minimum time and
// falls back to the idle LED code when the classifier goes quiet.
`timescale 1ns/1ps
module class_result_filter
  import class_result_filter_pkg::*;
#(
  parameter int                NUM_CLASSES    = CRF_NUM_CLASSES,
  parameter int                CONFIRM_CNT    = 3,
  parameter int                HOLD_CYCLES    = 50000000,
  parameter int                TIMEOUT_CYCLES = 100000000,
  parameter logic [CODE_W-1:0] IDLE_CODE      = CRF_IDLE_CODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_class,
  output logic [CODE_W-1:0] output_val,
  output logic              out_update
);
  localparam int MW = $clog2(CONFIRM_CNT + 1);

  state_e            state, nxt_state;
  logic [CODE_W-1:0] cand, nxt_cand, nxt_out;
  logic [MW-1:0]     match, nxt_match, match_inc;
  logic              nxt_upd, go_commit, go_idle;
  logic              hold_clr, hold_en, hold_tc;
  logic              tmo_clr, tmo_en, tmo_tc, tmo_hit;
  logic              acc, cls_ok, v_acc, i_acc, showing;

  assign acc     = in_valid & in_ready;
  assign cls_ok  = ({29'd0, in_class} < 32'(NUM_CLASSES));
  assign v_acc   = acc & cls_ok;
  assign i_acc   = acc & ~cls_ok;
  assign showing = (output_val != IDLE_CODE);

  assign hold_en = (state == ST_HOLD);
  // Silence only matters while a real class is on the LEDs.
  assign tmo_en  = (state == ST_DISPLAY || state == ST_CONFIRM) && showing;
  assign tmo_hit = tmo_en & tmo_tc;

  assign match_inc = (match >= MW'(CONFIRM_CNT)) ? match : match + MW'(1);

  class_result_filter_cycle_timer #(.MAX(HOLD_CYCLES)) u_hold_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hold_clr),
    .en    (hold_en),
    .tc    (hold_tc)
  );

  class_result_filter_cycle_timer #(.MAX(TIMEOUT_CYCLES)) u_tmo_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo_tc)
  );

  always_comb begin
    nxt_state = state;
    nxt_cand  = cand;
    nxt_match = match;
    nxt_out   = output_val;
    nxt_upd   = 1'b0;
    hold_clr  = 1'b0;
    tmo_clr   = 1'b0;
    go_commit = 1'b0;
    go_idle   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (v_acc) begin
          nxt_cand  = in_class;
          nxt_match = MW'(1);
          if (CONFIRM_CNT == 1) go_commit = 1'b1;
          else                  nxt_state = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        if (v_acc) begin
          tmo_clr = 1'b1;
          if (in_class == cand) begin
            nxt_match = match_inc;
            if (match_inc >= MW'(CONFIRM_CNT)) go_commit = 1'b1;
          end else if (in_class == output_val) begin
            // Classifier went back to what is already shown: drop the candidate.
            nxt_match = '0;
            nxt_state = ST_DISPLAY;
          end else begin
            nxt_cand  = in_class;
            nxt_match = MW'(1);
            if (CONFIRM_CNT == 1) go_commit = 1'b1;
          end
        end else begin
          if (i_acc) begin
            nxt_match = '0;
            nxt_state = showing ? ST_DISPLAY : ST_IDLE;
          end
          if (tmo_hit) go_idle = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_tc) begin
          nxt_state = ST_DISPLAY;
          tmo_clr   = 1'b1;
        end
      end
      ST_DISPLAY: begin
        if (v_acc) begin
          tmo_clr = 1'b1;
          if (in_class != output_val) begin
            nxt_cand  = in_class;
            nxt_match = MW'(1);
            if (CONFIRM_CNT == 1) go_commit = 1'b1;
            else                  nxt_state = ST_CONFIRM;
          end
        end else if (tmo_hit) begin
          go_idle = 1'b1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    if (go_commit) begin
      nxt_out   = in_class;
      nxt_upd   = 1'b1;
      nxt_match = '0;
      hold_clr  = 1'b1;
      nxt_state = ST_HOLD;
    end
    // A valid accept never coexists with go_idle, so accepts win over the timeout.
    if (go_idle) begin
      nxt_out   = IDLE_CODE;
      nxt_upd   = 1'b1;
      nxt_cand  = '0;
      nxt_match = '0;
      tmo_clr   = 1'b1;
      nxt_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      output_val <= IDLE_CODE;
      in_ready   <= 1'b0;
      out_update <= 1'b0;
      cand       <= '0;
      match      <= '0;
    end else begin
      state      <= nxt_state;
      output_val <= nxt_out;
      in_ready   <= (nxt_state != ST_HOLD);
      out_update <= nxt_upd;
      cand       <= nxt_cand;
      match      <= nxt_match;
    end
  end

endmodule

// File: tb/tb_class_result_filter.sv
// Directed bench for class_result_filter with CONFIRM_CNT=3, HOLD_CYCLES=8, TIMEOUT_CYCLES=20.
`timescale 1ns/1ps
module tb_class_result_filter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_class;
  logic [2:0] output_val;
  logic       out_update;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;

  class_result_filter #(
    .NUM_CLASSES    (5),
    .CONFIRM_CNT    (3),
    .HOLD_CYCLES    (8),
    .TIMEOUT_CYCLES (20),
    .IDLE_CODE      (3'b111)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .output_val (output_val),
    .out_update (out_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && out_update) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("ready_wait", 32'(in_ready), 1);
  endtask

  task automatic send(input logic [2:0] c);
    wait_ready();
    in_valid = 1'b1;
    in_class = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int u0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_class = 3'd0;
    tick();

    // 1. reset values, then three accepts of class 2
    chk("rst_out", 32'(output_val), 7);
    chk("rst_rdy", 32'(in_ready), 0);
    chk("rst_upd", 32'(out_update), 0);
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", 32'(in_ready), 1);
    send(3'd2);
    send(3'd2);
    chk("t1_two_2s", 32'(output_val), 7);
    send(3'd2);
    chk("t1_commit", 32'(output_val), 2);
    chk("t1_pulse", 32'(out_update), 1);
    chk("t1_hold_rdy", 32'(in_ready), 0);

    // 3. keep in_valid high through the hold window
    in_valid = 1'b1;
    in_class = 3'd3;
    n = 0;
    while (!in_ready && n < 30) begin
      n++;
      tick();
      if (n == 1) chk("t1_pulse_len", 32'(out_update), 0);
    end
    in_valid = 1'b0;
    chk("t3_hold_len", 32'(n), 8);
    chk("t3_out_held", 32'(output_val), 2);
    chk("t1_upd_count", 32'(upd_cnt), 1);
    // a 3 swallowed during hold would make these two commit
    send(3'd3);
    send(3'd3);
    chk("t3_no_consume", 32'(output_val), 2);
    send(3'd2);
    chk("t3_abort", 32'(output_val), 2);

    // 2. 1,1,4,4,4
    u0 = upd_cnt;
    send(3'd1);
    send(3'd1);
    chk("t2_after_1s", 32'(output_val), 2);
    send(3'd4);
    send(3'd4);
    chk("t2_two_4s", 32'(output_val), 2);
    send(3'd4);
    chk("t2_commit4", 32'(output_val), 4);
    chk("t2_pulse", 32'(out_update), 1);
    tick();
    chk("t2_upd_count", 32'(upd_cnt - u0), 1);

    // 4. silent timeout from DISPLAY
    wait_ready();
    idle(19);
    chk("t4_before_tmo", 32'(output_val), 4);
    tick();
    chk("t4_tmo_out", 32'(output_val), 7);
    chk("t4_tmo_pulse", 32'(out_update), 1);
    tick();
    chk("t4_idle_rdy", 32'(in_ready), 1);

    // 5. showing 4, then 3,3,4 aborts and restarts the timeout
    send(3'd4);
    send(3'd4);
    send(3'd4);
    chk("t5_commit4", 32'(output_val), 4);
    wait_ready();
    idle(10);
    send(3'd3);
    send(3'd3);
    send(3'd4);
    chk("t5_abort_out", 32'(output_val), 4);
    idle(19);
    chk("t5_tmo_restart", 32'(output_val), 4);
    tick();
    chk("t5_tmo_out", 32'(output_val), 7);

    // 6. invalid code ignored in IDLE and DISPLAY
    send(3'd6);
    send(3'd1);
    send(3'd1);
    chk("t6_idle_inv", 32'(output_val), 7);
    send(3'd1);
    chk("t6_commit1", 32'(output_val), 1);
    wait_ready();
    send(3'd6);
    chk("t6_disp_inv", 32'(output_val), 1);
    idle(18);
    chk("t6_tmo_kept", 32'(output_val), 1);
    tick();
    chk("t6_tmo_out", 32'(output_val), 7);

    // async reset mid-CONFIRM
    send(3'd2);
    send(3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstc_rdy", 32'(in_ready), 0);
    chk("rstc_out", 32'(output_val), 7);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rstc_rdy_back", 32'(in_ready), 1);

    // async reset mid-HOLD, pulse still high
    send(3'd2);
    send(3'd2);
    chk("rsth_pre", 32'(output_val), 7);
    send(3'd2);
    chk("rsth_commit", 32'(output_val), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rsth_out", 32'(output_val), 7);
    chk("rsth_rdy", 32'(in_ready), 0);
    chk("rsth_upd", 32'(out_update), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rsth_rdy_back", 32'(in_ready), 1);
    chk("rsth_out_back", 32'(output_val), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
